// File: rtl/decompression_arbiter_if.sv
// Stream bundle around the decompression arbiter: framed input, per-core page
// bodies, per-core decompressed returns and the reassembled output.
interface decompression_arbiter_if #(
    parameter int N_CORES   = 4,
    parameter int DATA_BITS = 512
);
    localparam int KEEP_BITS = DATA_BITS / 8;

    logic [DATA_BITS-1:0]         i_tdata;
    logic [KEEP_BITS-1:0]         i_tkeep;
    logic                         i_tlast;
    logic                         i_tvalid;
    logic                         i_tready;

    logic [N_CORES*DATA_BITS-1:0] c_tdata;
    logic [N_CORES*KEEP_BITS-1:0] c_tkeep;
    logic [N_CORES-1:0]           c_tlast;
    logic [N_CORES-1:0]           c_tvalid;
    logic [N_CORES-1:0]           c_tready;

    logic [N_CORES*DATA_BITS-1:0] d_tdata;
    logic [N_CORES*KEEP_BITS-1:0] d_tkeep;
    logic [N_CORES-1:0]           d_tlast;
    logic [N_CORES-1:0]           d_tvalid;
    logic [N_CORES-1:0]           d_tready;

    logic [DATA_BITS-1:0]         o_tdata;
    logic [KEEP_BITS-1:0]         o_tkeep;
    logic                         o_tlast;
    logic                         o_tvalid;
    logic                         o_tready;

    modport slave (
        input  i_tdata, i_tkeep, i_tlast, i_tvalid,
        output i_tready,
        output c_tdata, c_tkeep, c_tlast, c_tvalid,
        input  c_tready,
        input  d_tdata, d_tkeep, d_tlast, d_tvalid,
        output d_tready,
        output o_tdata, o_tkeep, o_tlast, o_tvalid,
        input  o_tready
    );

    modport master (
        output i_tdata, i_tkeep, i_tlast, i_tvalid,
        input  i_tready,
        input  c_tdata, c_tkeep, c_tlast, c_tvalid,
        output c_tready,
        output d_tdata, d_tkeep, d_tlast, d_tvalid,
        input  d_tready,
        input  o_tdata, o_tkeep, o_tlast, o_tvalid,
        output o_tready
    );
endinterface

// File: rtl/decompression_arbiter.sv
// Strips page headers, deals page bodies round-robin to the decompression cores
// and merges their outputs back in dispatch order, checking each page length.
module decompression_arbiter #(
    parameter int N_CORES   = 4,
    parameter int DATA_BITS = 512,
    parameter int SIZE_W    = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    decompression_arbiter_if.slave bus,
    output logic                   err_proto,
    output logic                   err_len,
    output logic [31:0]            pages_out
);
    localparam int KEEP_BITS  = DATA_BITS / 8;
    localparam int PC_W       = $clog2(KEEP_BITS) + 1;
    localparam int CNT_W      = SIZE_W + 1;
    localparam int SEL_W      = $clog2(N_CORES);
    localparam int META_W     = SIZE_W + 1;
    localparam int FIFO_DEPTH = 2 * N_CORES;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);

    typedef enum logic {ST_HDR, ST_BODY} state_t;

    function automatic logic [PC_W-1:0] popcnt(input logic [KEEP_BITS-1:0] k);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < KEEP_BITS; i++) n = n + PC_W'(k[i]);
        return n;
    endfunction

    state_t             state_q, state_d;
    logic [SIZE_W-1:0]  com_q, com_d, uncom_q, uncom_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_succ, ocnt_q, ocnt_succ;
    logic [SEL_W-1:0]   in_sel_q, in_sel_d, out_sel_q;
    logic               err_proto_q, err_len_q;
    logic [31:0]        pages_q;

    logic [META_W-1:0]  meta_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]     meta_cnt_q;
    logic               meta_full, meta_valid, meta_push, meta_pop;
    logic [META_W-1:0]  meta_rd;

    logic               i_tready_c, page_end, proto_err_c;
    logic [N_CORES-1:0] c_tvalid_c, c_tlast_c, d_tready_c;
    logic [DATA_BITS-1:0] o_tdata_c;
    logic [KEEP_BITS-1:0] o_tkeep_c;
    logic               o_tvalid_c, o_tlast_c, o_hs;

    assign meta_full  = (meta_cnt_q == (PTR_W+1)'(FIFO_DEPTH));
    assign meta_valid = (meta_cnt_q != '0);
    assign meta_rd    = meta_mem[rd_ptr_q];

    // Input side: header parse, then steer the body to exactly one core.
    always_comb begin
        state_d     = state_q;
        com_d       = com_q;
        uncom_d     = uncom_q;
        cnt_d       = cnt_q;
        in_sel_d    = in_sel_q;
        i_tready_c  = 1'b0;
        c_tvalid_c  = '0;
        c_tlast_c   = '0;
        meta_push   = 1'b0;
        proto_err_c = 1'b0;
        cnt_succ    = cnt_q + CNT_W'(popcnt(bus.i_tkeep));
        page_end    = (cnt_succ >= {1'b0, com_q}) || bus.i_tlast;
        case (state_q)
            ST_HDR: begin
                i_tready_c = aresetn && !meta_full;
                if (bus.i_tvalid && i_tready_c) begin
                    com_d   = bus.i_tdata[SIZE_W-1:0];
                    uncom_d = bus.i_tdata[2*SIZE_W-1:SIZE_W];
                    cnt_d   = '0;
                    if (bus.i_tkeep != KEEP_BITS'(4'hF)) proto_err_c = 1'b1;
                    if (bus.i_tdata[SIZE_W-1:0] == '0 || bus.i_tlast) proto_err_c = 1'b1;
                    else state_d = ST_BODY;
                end
            end
            ST_BODY: begin
                c_tvalid_c[in_sel_q] = bus.i_tvalid;
                c_tlast_c[in_sel_q]  = page_end;
                i_tready_c           = bus.c_tready[in_sel_q];
                if (bus.i_tvalid && i_tready_c) begin
                    cnt_d = cnt_succ;
                    if (page_end) begin
                        meta_push = 1'b1;
                        state_d   = ST_HDR;
                        in_sel_d  = (in_sel_q == SEL_W'(N_CORES-1)) ? '0 : in_sel_q + 1'b1;
                        if (cnt_succ > {1'b0, com_q} || (bus.i_tlast && cnt_succ < {1'b0, com_q}))
                            proto_err_c = 1'b1;
                    end
                end
            end
            default: state_d = ST_HDR;
        endcase
    end

    // Output side: only the core whose page is next in order may hand over data.
    always_comb begin
        d_tready_c            = '0;
        d_tready_c[out_sel_q] = meta_valid && bus.o_tready;
        o_tdata_c  = bus.d_tdata[out_sel_q*DATA_BITS +: DATA_BITS];
        o_tkeep_c  = bus.d_tkeep[out_sel_q*KEEP_BITS +: KEEP_BITS];
        o_tvalid_c = meta_valid && bus.d_tvalid[out_sel_q];
        o_tlast_c  = meta_valid && bus.d_tlast[out_sel_q] && meta_rd[0];
        o_hs       = o_tvalid_c && bus.o_tready;
        meta_pop   = o_hs && bus.d_tlast[out_sel_q];
        ocnt_succ  = ocnt_q + CNT_W'(popcnt(o_tkeep_c));
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= ST_HDR;
            com_q       <= '0;
            uncom_q     <= '0;
            cnt_q       <= '0;
            in_sel_q    <= '0;
            out_sel_q   <= '0;
            ocnt_q      <= '0;
            err_proto_q <= 1'b0;
            err_len_q   <= 1'b0;
            pages_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            meta_cnt_q  <= '0;
        end else begin
            state_q  <= state_d;
            com_q    <= com_d;
            uncom_q  <= uncom_d;
            cnt_q    <= cnt_d;
            in_sel_q <= in_sel_d;
            if (proto_err_c) err_proto_q <= 1'b1;
            if (o_hs) ocnt_q <= meta_pop ? '0 : ocnt_succ;
            if (meta_pop) begin
                out_sel_q <= (out_sel_q == SEL_W'(N_CORES-1)) ? '0 : out_sel_q + 1'b1;
                pages_q   <= pages_q + 32'd1;
                if (ocnt_succ != {1'b0, meta_rd[META_W-1:1]}) err_len_q <= 1'b1;
            end
            if (meta_push)
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
            if (meta_pop)
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
            case ({meta_push, meta_pop})
                2'b10:   meta_cnt_q <= meta_cnt_q + 1'b1;
                2'b01:   meta_cnt_q <= meta_cnt_q - 1'b1;
                default: meta_cnt_q <= meta_cnt_q;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (meta_push) meta_mem[wr_ptr_q] <= {uncom_q, bus.i_tlast};
    end

    // Every core sees the input beat; only the selected one gets tvalid.
    for (genvar gi = 0; gi < N_CORES; gi++) begin : g_bcast
        assign bus.c_tdata[gi*DATA_BITS +: DATA_BITS] = bus.i_tdata;
        assign bus.c_tkeep[gi*KEEP_BITS +: KEEP_BITS] = bus.i_tkeep;
    end

    assign bus.i_tready = i_tready_c;
    assign bus.c_tvalid = c_tvalid_c;
    assign bus.c_tlast  = c_tlast_c;
    assign bus.d_tready = d_tready_c;
    assign bus.o_tdata  = o_tdata_c;
    assign bus.o_tkeep  = o_tkeep_c;
    assign bus.o_tvalid = o_tvalid_c;
    assign bus.o_tlast  = o_tlast_c;
    assign err_proto    = err_proto_q;
    assign err_len      = err_len_q;
    assign pages_out    = pages_q;
endmodule

// File: doc/decompression_arbiter.md
# decompression_arbiter

Receive-side counterpart of the page compressor. It accepts a framed stream of compressed pages, one 32-bit header beat per page followed by `com_size` bytes of body, with `tlast` on the final page only. It strips each header and dispatches the page bodies round-robin to `N_CORES` external decompression cores. It then collects the core outputs in dispatch order into one output stream, marking `tlast` on the last byte of the last page and checking every decompressed length against the header.

## Interface
- `N_CORES`, 4: number of decompression cores, at least 2.
- `DATA_BITS`, 512: AXI-Stream data width; keep width is `DATA_BITS/8`.
- `SIZE_W`, 16: width of the size fields in the header.
- `aclk` in 1: clock.
- `aresetn` in 1: reset, synchronous, active-low; clock `aclk`.
- `i_tdata`/`i_tkeep`/`i_tlast`/`i_tvalid` in; `i_tready` out: framed compressed stream.
- `c_tdata` out `N_CORES*DATA_BITS`; `c_tkeep` out `N_CORES*DATA_BITS/8`; `c_tlast`/`c_tvalid` out `N_CORES`; `c_tready` in `N_CORES`: page bodies to the cores, slice i belongs to core i.
- `d_tdata`/`d_tkeep`/`d_tlast`/`d_tvalid` in (same slicing); `d_tready` out `N_CORES`: decompressed data from the cores.
- `o_tdata`/`o_tkeep`/`o_tlast`/`o_tvalid` out; `o_tready` in: reassembled output stream.
- `err_proto` out 1: sticky framing error.
- `err_len` out 1: sticky decompressed-length mismatch.
- `pages_out` out 32: count of completed output pages.

## Operation
Input FSM has two states, HDR and BODY.
- **HDR**
  - `i_tready` = metadata FIFO not full.
  - On a handshake, latch `com_size = i_tdata[15:0]` and `uncom_size = i_tdata[31:16]`, clear the byte counter, go to BODY.
  - Header `tkeep` ≠ `0xF`: set `err_proto`, parse the beat anyway.
  - `com_size == 0` or `i_tlast` on the header beat: set `err_proto`, stay in HDR, dispatch nothing, push no metadata.
- **BODY**
  - Forward the input beat to core `in_sel` only. Its `c_tvalid[in_sel] = i_tvalid`, `i_tready = c_tready[in_sel]`. Every other core sees `c_tvalid = 0`.
  - `cnt_succ = cnt + popcount(i_tkeep)`.
  - Page ends on the beat where `cnt_succ >= com_size` or `i_tlast = 1`. On that beat: `c_tlast = 1`; push `{uncom_size, i_tlast}` to the metadata FIFO; advance `in_sel` (wrapping `N_CORES-1` to 0); return to HDR.
  - `cnt_succ > com_size`, or `i_tlast` with `cnt_succ < com_size`: set `err_proto`; the page still ends on that beat.
- **Metadata FIFO**
  - Depth `2*N_CORES`, width `SIZE_W+1`.
  - Pop on the output beat that carries `d_tlast`.
- **Output collector**
  - Source core `out_sel`, starting at 0 and advancing in the same wrap order as `in_sel`.
  - `o_tvalid = meta_valid & d_tvalid[out_sel]`.
  - `d_tready[out_sel] = meta_valid & o_tready`; every other core gets `d_tready = 0`.
  - `o_tdata`/`o_tkeep` pass through from core `out_sel`.
  - `o_tlast = d_tlast[out_sel] & meta.last`.
  - Output byte counter accumulates `popcount(o_tkeep)` per handshake.
  - On the `d_tlast` beat: if the final count ≠ `meta.uncom_size`, set `err_len`. Then clear the counter, advance `out_sel`, and increment `pages_out` (wrapping at 2^32).
- Size arithmetic is `SIZE_W+1` bits wide to catch overshoot without wrap; popcount is `$clog2(DATA_BITS/8)+1` bits.

## Timing
- Reset values: `i_tready` 0 (1 from the first cycle after reset, FSM in HDR with the metadata FIFO empty); every `c_tvalid`, `d_tready`, `o_tvalid`, `o_tlast` 0; `err_*` 0; `pages_out` 0; `in_sel`/`out_sel` 0; FSM in HDR.
- Header beat costs one input cycle. The first body beat can be accepted the very next cycle.
- Input-to-core and core-to-output paths are combinational: zero added latency.
- Metadata pushed at cycle t is visible to the collector at t+1. A core output beat presented before its metadata is valid is stalled, not dropped.
- Metadata FIFO full: HDR holds `i_tready = 0` until a pop. A simultaneous push and pop on a full FIFO is allowed.
- Out-of-order core completion is never reordered: a later core waits until `out_sel` reaches it.
- Reset mid-page discards all state; the cores are reset by the same `aresetn`.

## Test plan
- Single page: header `0x1000_0040` (uncom 4096, com 64), then one 64-byte body beat with `tlast` → core 0 gets one beat with `c_tlast=1`; core 0 returns 4096 bytes → 64 output beats, `o_tlast` on beat 64, `pages_out=1`, no errors.
- Five pages with `N_CORES=4` → dispatch order 0,1,2,3,0; output is in page order even when core 2 finishes before core 1; only page 5 carries `o_tlast`.
- Header com 100 with body beats of 64+64 bytes → `err_proto=1`, page still ends on the second beat.
- Core returns 4032 bytes for uncom 4096 → `err_len=1`, `pages_out` still increments.
- Hold `o_tready=0` while sending 9 pages → `i_tready` drops at the header of page 9 (metadata FIFO full); releasing `o_tready` drains everything with no data loss.
- Assert `aresetn=0` mid-body → all outputs at reset values the next cycle; a fresh page afterwards is dispatched to core 0.
